// File: rtl/vfu_out_serializer.sv
// Vector-to-scalar serializer: buffers N-lane FP16 vectors in a small FIFO and
// streams them out one lane per handshake. Define VFU_SER_OVF_FLAG_EN for a sticky ovf output.
module vfu_out_serializer #(
    parameter int N     = 4,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_tvalid,
    input  logic [N*16-1:0] in_tdata,
    output logic            in_tready,
    output logic            out_tvalid,
    output logic [15:0]     out_tdata,
    output logic            out_tlast,
    input  logic            out_tready
`ifdef VFU_SER_OVF_FLAG_EN
    ,
    output logic            ovf
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int LW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        EMPTY  = 1'b0,
        STREAM = 1'b1
    } state_t;

    logic [N*16-1:0] mem [DEPTH];
    logic [15:0]     head_lanes [N];

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]   lane_q, lane_d;
    logic            last_q, last_d;
    logic            push, hs, pop;

    assign out_tvalid = (state_q == STREAM);
    assign out_tlast  = last_q;
    assign in_tready  = (count_q < CW'(DEPTH));

    always_comb begin
        push     = in_tvalid && (count_q < CW'(DEPTH));
        hs       = out_tvalid && out_tready;
        pop      = hs && (lane_q == LW'(N - 1));
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        lane_d   = lane_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            lane_d   = '0;
        end else if (hs) begin
            lane_d = lane_q + 1'b1;
        end
        // Push and pop in the same cycle cancel out.
        count_d = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
        state_d = (count_d != '0) ? STREAM : EMPTY;
        last_d  = (count_d != '0) && (lane_d == LW'(N - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= EMPTY;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            lane_q   <= '0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            lane_q   <= lane_d;
            last_q   <= last_d;
        end
    end

    // Storage is not reset; writes are blocked while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem[wr_ptr_q] <= in_tdata;
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            assign head_lanes[gi] = mem[rd_ptr_q][gi*16 +: 16];
        end
    endgenerate

    assign out_tdata = head_lanes[lane_q];

`ifdef VFU_SER_OVF_FLAG_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q | (in_tvalid && !in_tready);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_vfu_out_serializer.sv
// Directed bench for vfu_out_serializer (N=4, DEPTH=4); ovf checks follow VFU_SER_OVF_FLAG_EN.
module tb_vfu_out_serializer;

    localparam int N     = 4;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_tvalid = 1'b0;
    logic [N*16-1:0] in_tdata = '0;
    logic            in_tready;
    logic            out_tvalid;
    logic [15:0]     out_tdata;
    logic            out_tlast;
    logic            out_tready = 1'b0;
`ifdef VFU_SER_OVF_FLAG_EN
    logic            ovf;
`endif

    int checks   = 0;
    int failures = 0;

    vfu_out_serializer #(.N(N), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_tvalid (in_tvalid),
        .in_tdata  (in_tdata),
        .in_tready (in_tready),
        .out_tvalid(out_tvalid),
        .out_tdata (out_tdata),
        .out_tlast (out_tlast),
        .out_tready(out_tready)
`ifdef VFU_SER_OVF_FLAG_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] word(input int k, input int j);
        return 16'(16'h1000 + k * 16 + j);
    endfunction

    function automatic logic [N*16-1:0] mkvec(input int k);
        logic [N*16-1:0] v;
        for (int j = 0; j < N; j++) v[j*16 +: 16] = word(k, j);
        return v;
    endfunction

    task automatic expect_word(input string tag, input logic [15:0] data, input logic last);
        $display("%s: valid=%0b data=%h last=%0b (want data=%h last=%0b)",
                 tag, out_tvalid, out_tdata, out_tlast, data, last);
        check({tag, ".valid"}, {15'd0, out_tvalid}, 16'd1);
        check({tag, ".data"}, out_tdata, data);
        check({tag, ".last"}, {15'd0, out_tlast}, {15'd0, last});
    endtask

    task automatic expect_idle(input string tag);
        $display("%s: valid=%0b last=%0b in_tready=%0b", tag, out_tvalid, out_tlast, in_tready);
        check({tag, ".valid"}, {15'd0, out_tvalid}, 16'd0);
        check({tag, ".last"}, {15'd0, out_tlast}, 16'd0);
        check({tag, ".in_tready"}, {15'd0, in_tready}, 16'd1);
    endtask

    // Drains vector k with out_tready high, one word per cycle.
    task automatic drain_vec(input string tag, input int k);
        out_tready = 1'b1;
        for (int j = 0; j < N; j++) begin
            expect_word($sformatf("%s.v%0d.l%0d", tag, k, j), word(k, j), j == N - 1);
            step();
        end
    endtask

    initial begin
        int pushed;
        int words;

        // Reset state
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        expect_idle("reset");
`ifdef VFU_SER_OVF_FLAG_EN
        check("reset.ovf", {15'd0, ovf}, 16'd0);
`endif

        // Single vector, lane 0 first, one-cycle latency
        in_tdata   = {16'h4400, 16'h4200, 16'h4000, 16'h3C00};
        in_tvalid  = 1'b1;
        out_tready = 1'b1;
        step();
        in_tvalid = 1'b0;
        expect_word("single.l0", 16'h3C00, 1'b0);
        step();
        expect_word("single.l1", 16'h4000, 1'b0);
        step();
        expect_word("single.l2", 16'h4200, 1'b0);
        step();
        expect_word("single.l3", 16'h4400, 1'b1);
        step();
        expect_idle("single.done");

        // Stall on lane 1
        in_tvalid = 1'b1;
        step();
        in_tvalid = 1'b0;
        expect_word("stall.l0", 16'h3C00, 1'b0);
        step();
        expect_word("stall.l1", 16'h4000, 1'b0);
        out_tready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            expect_word($sformatf("stall.hold%0d", c), 16'h4000, 1'b0);
        end
        out_tready = 1'b1;
        step();
        expect_word("stall.l2", 16'h4200, 1'b0);
        step();
        expect_word("stall.l3", 16'h4400, 1'b1);
        step();
        expect_idle("stall.done");

        // Overflow: five pushes into a stalled 4-deep FIFO
        out_tready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            $display("ovf.push%0d: in_tready=%0b", k, in_tready);
            check($sformatf("ovf.push%0d.in_tready", k), {15'd0, in_tready}, {15'd0, k <= DEPTH});
            in_tdata  = mkvec(k);
            in_tvalid = 1'b1;
            step();
        end
        in_tvalid = 1'b0;
        check("ovf.full.in_tready", {15'd0, in_tready}, 16'd0);
`ifdef VFU_SER_OVF_FLAG_EN
        check("ovf.flag", {15'd0, ovf}, 16'd1);
`endif
        for (int k = 1; k <= 4; k++) drain_vec("ovf", k);
        expect_idle("ovf.done");

        // Pointer wrap: 10 vectors streamed with out_tready high
        out_tready = 1'b1;
        pushed = 0;
        words  = 0;
        for (int c = 0; c < 200 && words < 40; c++) begin
            if (out_tvalid) begin
                expect_word($sformatf("wrap.w%0d", words), word(20 + words / N, words % N),
                            (words % N) == N - 1);
                words++;
            end
            if (pushed < 10 && in_tready) begin
                in_tdata  = mkvec(20 + pushed);
                in_tvalid = 1'b1;
                pushed++;
            end else begin
                in_tvalid = 1'b0;
            end
            step();
        end
        in_tvalid = 1'b0;
        $display("wrap.count: words=%0d pushed=%0d", words, pushed);
        check("wrap.words", 16'(words), 16'd40);
        expect_idle("wrap.done");

        // Reset mid-stream on lane 2, with a push offered during reset
        in_tdata  = mkvec(40);
        in_tvalid = 1'b1;
        step();
        in_tvalid = 1'b0;
        expect_word("rst.l0", word(40, 0), 1'b0);
        step();
        expect_word("rst.l1", word(40, 1), 1'b0);
        step();
        expect_word("rst.l2", word(40, 2), 1'b0);
        rst       = 1'b0;
        in_tdata  = mkvec(41);
        in_tvalid = 1'b1;
        step();
        rst       = 1'b1;
        in_tvalid = 1'b0;
        expect_idle("rst.after");
`ifdef VFU_SER_OVF_FLAG_EN
        check("rst.ovf", {15'd0, ovf}, 16'd0);
`endif
        step();
        expect_idle("rst.nopush");
        in_tdata  = mkvec(42);
        in_tvalid = 1'b1;
        step();
        in_tvalid = 1'b0;
        drain_vec("rst.next", 42);
        expect_idle("rst.done");

        // Simultaneous push and pop with two vectors stored
        out_tready = 1'b0;
        in_tdata   = mkvec(50);
        in_tvalid  = 1'b1;
        step();
        in_tdata = mkvec(51);
        step();
        in_tvalid  = 1'b0;
        out_tready = 1'b1;
        expect_word("sim.a0", word(50, 0), 1'b0);
        step();
        expect_word("sim.a1", word(50, 1), 1'b0);
        step();
        expect_word("sim.a2", word(50, 2), 1'b0);
        step();
        expect_word("sim.a3", word(50, 3), 1'b1);
        check("sim.pre.in_tready", {15'd0, in_tready}, 16'd1);
        in_tdata  = mkvec(52);
        in_tvalid = 1'b1;
        step();
        in_tvalid  = 1'b0;
        out_tready = 1'b0;
        expect_word("sim.b0", word(51, 0), 1'b0);
        // Count must be 2: exactly two more pushes fill the FIFO
        in_tdata  = mkvec(53);
        in_tvalid = 1'b1;
        step();
        check("sim.cnt3.in_tready", {15'd0, in_tready}, 16'd1);
        in_tdata = mkvec(54);
        step();
        in_tvalid = 1'b0;
        check("sim.cnt4.in_tready", {15'd0, in_tready}, 16'd0);
        for (int k = 51; k <= 54; k++) drain_vec("sim", k);
        expect_idle("sim.done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vfu_out_serializer.md
VFU_OUT_SERIALIZER -- requirements
Module: vfu_out_serializer

Interface
REQ-001 SHALL have parameter N, default 4: number of FP16 lanes per input vector (N >= 2).
REQ-002 SHALL have parameter DEPTH, default 4: vector FIFO depth (power of 2, >= 2).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_tvalid  input  1  input vector valid; driven from the VFU out_tvalid.
REQ-006 SHALL have port in_tdata  input  N*16  packed FP16 vector; lane i occupies bits [i*16+15:i*16].
REQ-007 SHALL have port in_tready  output  1  FIFO not full (status only; the VFU has no backpressure).
REQ-008 SHALL have port out_tvalid  output  1  scalar output valid.
REQ-009 SHALL have port out_tdata  output  16  current FP16 lane word.
REQ-010 SHALL have port out_tlast  output  1  high with lane N-1 of each vector.
REQ-011 SHALL have port out_tready  input  1  downstream accepts the scalar.

Function
REQ-012 SHALL store accepted vectors in a DEPTH-entry FIFO with a count register (0..DEPTH) and wrapping read/write pointers.
REQ-013 SHALL push in_tdata at a rising edge only when in_tvalid=1 and count<DEPTH.
REQ-014 SHALL drive in_tready = (count<DEPTH), based on the registered count; a pop in the same cycle does not free a slot for that cycle's push.
REQ-015 SHALL drop any vector offered while count=DEPTH; stored contents stay unchanged.
REQ-016 SHALL implement two states: EMPTY (count=0, out_tvalid=0) and STREAM (count>0, out_tvalid=1).
REQ-017 SHALL hold a lane counter 0..N-1; out_tdata = head entry lane[lane counter], lane 0 first.
REQ-018 SHALL advance the lane counter only on handshake (out_tvalid & out_tready); out_tdata is stable while stalled.
REQ-019 SHALL assert out_tlast when lane counter = N-1 and out_tvalid=1.
REQ-020 SHALL, on the handshake with out_tlast=1, pop the head, reset the lane counter to 0, and advance the read pointer with wrap DEPTH-1 -> 0.
REQ-021 SHALL handle a simultaneous push and pop in one cycle with count unchanged.
REQ-022 SHALL give a latency of 1 cycle: a vector pushed into an empty FIFO at edge k gives out_tvalid=1 with lane 0 after edge k.
REQ-023 SHALL sustain 1 scalar per cycle with out_tready held high, i.e. one vector per N cycles.

Reset
REQ-024 SHALL, when rst=0 at a rising edge, set count=0, read pointer=0, write pointer=0, lane counter=0, out_tvalid=0, out_tlast=0 and in_tready=1.
REQ-025 SHALL leave FIFO storage unreset; out_tdata is don't-care while out_tvalid=0.
REQ-026 SHALL, on reset mid-stream, discard all stored vectors and any partially sent vector; no push is accepted during a reset cycle.

Configuration
REQ-027 SHALL, when macro VFU_SER_OVF_FLAG_EN is defined, add output port ovf (1 bit), reset to 0, set sticky at the edge where a vector is dropped (REQ-015), and cleared only by reset.
REQ-028 SHALL, when VFU_SER_OVF_FLAG_EN is undefined, omit port ovf and drop overflowing vectors silently; all other behaviour is identical.

Verification
REQ-029 SHALL verify single vector: push {4400,4200,4000,3C00} (lane3..0), out_tready=1 -> out_tdata 3C00,4000,4200,4400 on 4 consecutive cycles, out_tlast only with 4400, then out_tvalid=0.
REQ-030 SHALL verify stall: out_tready=0 for 3 cycles during lane 1 -> out_tdata holds 4000 and the lane counter does not advance; resuming out_tready gives 4200.
REQ-031 SHALL verify overflow: push 5 vectors on consecutive cycles with out_tready=0 and DEPTH=4 -> in_tready=0 after the 4th, 5th vector dropped, ovf=1 (macro on), output gives exactly vectors 1-4.
REQ-032 SHALL verify pointer wrap: 10 vectors streamed with out_tready=1 -> all 40 words are in order with no loss and count returns to 0.
REQ-033 SHALL verify reset mid-stream: rst=0 for one cycle while on lane 2 -> out_tvalid=0 and count=0 next cycle; ovf cleared; the next pushed vector starts at lane 0.
REQ-034 SHALL verify simultaneous push and pop: push at the same edge as the out_tlast handshake with count=2 -> count stays 2 and the next vector starts at lane 0 on the following cycle.
